// File: rtl/apb_ref_pkg.sv
// Shared definitions for the APB reference slave: bus-phase states,
// register addresses and CTRL bit positions.
package apb_ref_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } bus_state_t;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_INT_STAT = 1;
  localparam int ADDR_TMR_LOAD = 2;
  localparam int ADDR_TMR_VAL  = 3;
  localparam int ADDR_SCRATCH  = 4;

  localparam int CTRL_INT_EN = 0;
  localparam int CTRL_TMR_EN = 1;

endpackage

// File: rtl/apb_ref_slave_if.sv
// APB bus bundle between a master and the reference slave.
// Handshake: a transfer is a setup beat (PSEL=1, PENABLE=0) followed by one or
// more access beats (PSEL=1, PENABLE=1); it completes on the edge where PREADY=1.
interface apb_ref_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_ref_timer.sv
// Down-counting reload timer: loads on start, decrements while enabled and
// reloads with a one-cycle expiry pulse when it reaches zero.
module apb_ref_timer
  import apb_ref_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] tmr_val,
  output logic              expire
);

  logic [DATA_W-1:0] val_q;

  // Expiry is combinational so the register file can set its flag on the
  // same edge the counter reloads.
  assign expire  = en && (val_q == '0);
  assign tmr_val = val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else if (start) begin
      val_q <= load_val;
    end else if (en) begin
      if (val_q == '0) val_q <= load_val;
      else             val_q <= val_q - DATA_W'(1);
    end
  end

endmodule

// File: rtl/apb_ref_slave.sv
// APB reference slave: bus FSM, register file and timer instance.
// Define APB_WAIT_STATE_EN to insert one wait state in every transfer.
module apb_ref_slave
  import apb_ref_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                SYSCLK,
  input  logic                SYSRST,
  apb_ref_slave_if.slave      bus,
  output logic                INT_B,
  output bus_state_t          state_dbg
);

  bus_state_t        state_q;
  logic              setup_beat;
  logic              go_setup;
  logic              wr_en;
  logic              sel_ctrl, sel_int, sel_load, sel_val, sel_scratch;
  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] tmr_load_q;
  logic [DATA_W-1:0] scratch_q;
  logic [DATA_W-1:0] prdata_q;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] tmr_val;
  logic              int_stat_q;
  logic              int_b_q;
  logic              tmr_start;
  logic              tmr_expire;
  logic              w1c;

  assign setup_beat = bus.PSEL & ~bus.PENABLE;
  // The state records the phase of the beat just sampled, so the edge that
  // moves into SETUP is the edge ending the bus setup beat.
  assign go_setup   = setup_beat &
                      ((state_q == ST_IDLE) | ((state_q == ST_ACCESS) & bus.PREADY));
  assign wr_en      = bus.PSEL & bus.PENABLE & bus.PWRITE & bus.PREADY;

  assign sel_ctrl    = (bus.PADDR == ADDR_W'(ADDR_CTRL));
  assign sel_int     = (bus.PADDR == ADDR_W'(ADDR_INT_STAT));
  assign sel_load    = (bus.PADDR == ADDR_W'(ADDR_TMR_LOAD));
  assign sel_val     = (bus.PADDR == ADDR_W'(ADDR_TMR_VAL));
  assign sel_scratch = (bus.PADDR == ADDR_W'(ADDR_SCRATCH));

  assign tmr_start = wr_en & sel_ctrl & bus.PWDATA[CTRL_TMR_EN] & ~ctrl_q[CTRL_TMR_EN];
  assign w1c       = wr_en & sel_int & bus.PWDATA[0];

  assign bus.PRDATA = prdata_q;
  assign INT_B      = int_b_q;
  assign state_dbg  = state_q;

`ifdef APB_WAIT_STATE_EN
  logic pready_q;
  assign bus.PREADY = pready_q;
`else
  assign bus.PREADY = 1'b1;
`endif

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      state_q  <= ST_IDLE;
`ifdef APB_WAIT_STATE_EN
      pready_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE:   if (setup_beat) state_q <= ST_SETUP;
        ST_SETUP:  state_q <= ST_ACCESS;
        ST_ACCESS: begin
          if (!bus.PSEL)        state_q <= ST_IDLE;
          else if (bus.PREADY)  state_q <= setup_beat ? ST_SETUP : ST_IDLE;
        end
        default:   state_q <= ST_IDLE;
      endcase
`ifdef APB_WAIT_STATE_EN
      // Low for exactly the first access beat of every transfer.
      pready_q <= ~go_setup;
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl)         rd_mux = ctrl_q;
    else if (sel_int)     rd_mux = DATA_W'(int_stat_q);
    else if (sel_load)    rd_mux = tmr_load_q;
    else if (sel_val)     rd_mux = tmr_val;
    else if (sel_scratch) rd_mux = scratch_q;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      ctrl_q     <= '0;
      tmr_load_q <= '0;
      scratch_q  <= '0;
      prdata_q   <= '0;
      int_stat_q <= 1'b0;
      int_b_q    <= 1'b1;
    end else begin
      if (wr_en && sel_ctrl)    ctrl_q     <= bus.PWDATA;
      if (wr_en && sel_load)    tmr_load_q <= bus.PWDATA;
      if (wr_en && sel_scratch) scratch_q  <= bus.PWDATA;
      // Expiry beats a simultaneous clear so no event is lost.
      if (tmr_expire)  int_stat_q <= 1'b1;
      else if (w1c)    int_stat_q <= 1'b0;
      int_b_q <= ~(int_stat_q & ctrl_q[CTRL_INT_EN]);
      if (go_setup && !bus.PWRITE) prdata_q <= rd_mux;
    end
  end

  apb_ref_timer #(
    .DATA_W (DATA_W)
  ) u_timer (
    .clk      (SYSCLK),
    .rst      (SYSRST),
    .start    (tmr_start),
    .en       (ctrl_q[CTRL_TMR_EN]),
    .load_val (tmr_load_q),
    .tmr_val  (tmr_val),
    .expire   (tmr_expire)
  );

endmodule

// File: doc/apb_ref_slave.md
APB_REF_SLAVE -- requirements
Module: apb_ref_slave

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the PADDR width.
REQ-002 Parameter DATA_W, default 8, SHALL set the PWDATA/PRDATA width; registers are DATA_W bits.
REQ-003 SYSCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SYSRST  in  1  reset, synchronous, active-high.
REQ-005 PSEL  in  1  slave select.
REQ-006 PENABLE  in  1  APB access phase.
REQ-007 PWRITE  in  1  1 = write, 0 = read.
REQ-008 PADDR  in  ADDR_W  register address.
REQ-009 PWDATA  in  DATA_W  write data.
REQ-010 PREADY  out  1  transfer completes when high in access phase.
REQ-011 PRDATA  out  DATA_W  registered read data, the golden PRDATA for the bus monitor.
REQ-012 INT_B  out  1  active-low interrupt, registered, the golden INT_B for the bus monitor.

Function
REQ-013 Bus FSM SHALL have states IDLE, SETUP, ACCESS: IDLE->SETUP on PSEL&~PENABLE; SETUP->ACCESS unconditionally; ACCESS->SETUP on completion with PSEL&~PENABLE, else ->IDLE on completion; ACCESS holds while PREADY=0.
REQ-014 Register map SHALL be: 0x0 CTRL (bit0 INT_EN, bit1 TMR_EN, RW); 0x1 INT_STAT (bit0 timer expiry, write-1-to-clear); 0x2 TMR_LOAD (RW); 0x3 TMR_VAL (RO); 0x4 SCRATCH (RW); all other addresses read 0x00, writes ignored.
REQ-015 A write SHALL commit on the edge where PSEL&PENABLE&PWRITE&PREADY.
REQ-016 PRDATA SHALL load the addressed register on the edge ending SETUP of a read, be valid throughout ACCESS, and hold its value otherwise.
REQ-017 With TMR_EN=1, TMR_VAL SHALL decrement by 1 per cycle; at TMR_VAL=0 it SHALL reload from TMR_LOAD and set INT_STAT[0] on that same edge.
REQ-018 With TMR_EN=0, TMR_VAL SHALL hold; the 0->1 transition of TMR_EN SHALL load TMR_VAL from TMR_LOAD.
REQ-019 A write to TMR_LOAD while running SHALL take effect only at the next reload.
REQ-020 TMR_LOAD=0 with TMR_EN=1 SHALL set INT_STAT[0] every cycle.
REQ-021 Timer expiry and a W1C to INT_STAT[0] on the same edge: set SHALL win.
REQ-022 INT_B SHALL be registered as ~(INT_STAT[0]&INT_EN): one cycle after the INT_STAT/CTRL update.
REQ-023 PSEL deasserted in ACCESS (protocol violation) SHALL return FSM to IDLE with no write committed.

Reset
REQ-024 On SYSRST=1 at a clock edge, SHALL set FSM=IDLE, CTRL=0, INT_STAT=0, TMR_LOAD=0, TMR_VAL=0, SCRATCH=0, PRDATA=0, INT_B=1, PREADY=1.
REQ-025 Reset mid-transfer SHALL abort it; no write commits on the reset edge.

Configuration
REQ-026 Macro APB_WAIT_STATE_EN defined: PREADY=0 in the first ACCESS cycle and 1 in the second (every transfer is 3 cycles); undefined: PREADY tied to 1 (2-cycle transfers).

Structure
REQ-027 Shared package apb_ref_pkg SHALL hold the FSM state enum, register address constants and CTRL bit indices.
REQ-028 The timer (TMR_VAL counter, reload, expiry pulse) SHALL be the sub-module apb_ref_timer; the top level holds the FSM and register file.

Verification
REQ-029 Write 0x5A to 0x4, then read 0x4 -> PRDATA=0x5A during read ACCESS.
REQ-030 Read 0x7 (unmapped) -> PRDATA=0x00; write 0xFF to 0x7 then read 0x4 -> SCRATCH unchanged.
REQ-031 TMR_LOAD=3, CTRL=0x3 -> INT_STAT[0] set 4 cycles after TMR_EN goes high, INT_B=0 one cycle later; W1C 0x01 to 0x1 -> INT_B=1 one cycle after commit.
REQ-032 W1C to INT_STAT issued on the expiry edge -> INT_STAT[0] remains 1, INT_B stays 0.
REQ-033 SYSRST pulsed during ACCESS of a write of 0xAA to SCRATCH -> SCRATCH=0, PRDATA=0, INT_B=1, FSM=IDLE.
REQ-034 With APB_WAIT_STATE_EN, back-to-back reads -> PREADY low exactly one cycle per transfer, 3 cycles per transfer; without it, 2 cycles per transfer.
